// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out stream bundle for imm_gen_pipe.
// The master side feeds instructions and consumes immediates; the slave side is the extractor.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            instruction;
  logic [2:0]             sel_in;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [XLEN-1:0] imm;
  logic [2:0]             fmt;
  logic                   illegal;

  modport master (
    output in_valid, instruction, sel_in, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal
  );

  modport slave (
    input  in_valid, instruction, sel_in, out_ready,
    output in_ready, out_valid, imm, fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate extractor: decode, sign-extend to XLEN, one registered output
// stage backed by a single-entry skid buffer so in_ready never depends on out_ready.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_U    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]            ins_p0;
  logic [6:0]             opc_p0;
  logic [2:0]             f3_p0;
  logic [2:0]             fmt_p0;
  logic                   ill_p0;
  logic                   shift_p0;
  logic signed [31:0]     raw_p0;
  logic signed [XLEN-1:0] imm_p0;

  logic                   vld_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [2:0]             fmt_p1;
  logic                   ill_p1;
  logic                   skid_vld_p1;
  logic signed [XLEN-1:0] skid_imm_p1;
  logic [2:0]             skid_fmt_p1;
  logic                   skid_ill_p1;

  logic accept;
  logic out_free;

  // ---- p0: combinational decode of the incoming beat ----
  assign ins_p0 = bus.instruction;
  assign opc_p0 = ins_p0[6:0];
  assign f3_p0  = ins_p0[14:12];

  always_comb begin
    fmt_p0 = FMT_NONE;
    ill_p0 = 1'b0;
    if (AUTO_SEL) begin
      case (opc_p0)
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111:             fmt_p0 = FMT_I;
        7'b0110111, 7'b0010111:             fmt_p0 = FMT_U;
        7'b0100011:                         fmt_p0 = FMT_S;
        7'b1100011:                         fmt_p0 = FMT_B;
        7'b1101111:                         fmt_p0 = FMT_J;
        7'b0110011:                         fmt_p0 = FMT_NONE;
        7'b0011011: if (XLEN == 64) fmt_p0 = FMT_I; else ill_p0 = 1'b1;
        7'b0111011: if (XLEN != 64) ill_p0 = 1'b1;
        default:                            ill_p0 = 1'b1;
      endcase
    end else begin
      if (bus.sel_in > FMT_J) ill_p0 = 1'b1;
      else                    fmt_p0 = bus.sel_in;
    end
  end

  // Shift-immediates carry shamt in the I field; funct7 bits must not leak into IMM.
  assign shift_p0 = (fmt_p0 == FMT_I) &&
                    ((opc_p0 == 7'b0010011) || (opc_p0 == 7'b0011011)) &&
                    ((f3_p0 == 3'b001) || (f3_p0 == 3'b101));

  always_comb begin
    raw_p0 = '0;
    case (fmt_p0)
      FMT_I:   raw_p0 = {{20{ins_p0[31]}}, ins_p0[31:20]};
      FMT_S:   raw_p0 = {{20{ins_p0[31]}}, ins_p0[31:25], ins_p0[11:7]};
      FMT_B:   raw_p0 = {{19{ins_p0[31]}}, ins_p0[31], ins_p0[7], ins_p0[30:25],
                         ins_p0[11:8], 1'b0};
      FMT_U:   raw_p0 = {ins_p0[31:12], 12'b0};
      FMT_J:   raw_p0 = {{11{ins_p0[31]}}, ins_p0[31], ins_p0[19:12], ins_p0[20],
                         ins_p0[30:21], 1'b0};
      default: raw_p0 = '0;
    endcase
    if (shift_p0) begin
      raw_p0 = (XLEN == 64 && opc_p0 == 7'b0010011) ? {26'b0, ins_p0[25:20]}
                                                    : {27'b0, ins_p0[24:20]};
    end
  end

  assign imm_p0 = sext32(raw_p0);

  assign bus.in_ready = ~skid_vld_p1;
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_free     = ~vld_p1 | bus.out_ready;

  // ---- p1: output register and skid buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      fmt_p1      <= FMT_NONE;
      ill_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_fmt_p1 <= FMT_NONE;
      skid_ill_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (accept && out_free) begin
      vld_p1 <= 1'b1;
      imm_p1 <= imm_p0;
      fmt_p1 <= fmt_p0;
      ill_p1 <= ill_p0;
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
      skid_imm_p1 <= imm_p0;
      skid_fmt_p1 <= fmt_p0;
      skid_ill_p1 <= ill_p0;
    end else if (out_free && skid_vld_p1) begin
      vld_p1      <= 1'b1;
      imm_p1      <= skid_imm_p1;
      fmt_p1      <= skid_fmt_p1;
      ill_p1      <= skid_ill_p1;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.imm       = imm_p1;
  assign bus.fmt       = fmt_p1;
  assign bus.illegal   = ill_p1;

endmodule
